rectangle_round_ctrl: RTL and testbench

- Iterative RECTANGLE-80 encryption engine controller: sequences the 16-column bit-sliced S-box layer, AddRoundKey, ShiftRow and the 80-bit key schedule at one round per clock.
- Accepts a plaintext/key pair through a valid/ready-style start handshake, runs NR rounds plus final key whitening, and holds the ciphertext until acknowledged.
- Sits between the host/bus interface and the combinational round datapath. It instantiates the existing text S-box layer and a 4-column key S-box slice.

---
 rtl/rectangle_round_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rectangle_round_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rectangle_round_ctrl.sv
// RECTANGLE-80 iterative encryption controller: one round per clock, final key
// whitening, and a valid/ack hold of the ciphertext. Includes the column S-box slice.

module rectangle_sbox_cols #(
  parameter int COLS = 16
) (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
      4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
      4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
      4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // A column is one bit from each 16-bit row; row 0 supplies the nibble LSB.
  for (genvar j = 0; j < 16; j++) begin : g_col
    if (j < COLS) begin : g_sb
      logic [3:0] y;
      assign y          = sbox({din[48+j], din[32+j], din[16+j], din[j]});
      assign dout[j]    = y[0];
      assign dout[16+j] = y[1];
      assign dout[32+j] = y[2];
      assign dout[48+j] = y[3];
    end else begin : g_pass
      assign dout[j]    = din[j];
      assign dout[16+j] = din[16+j];
      assign dout[32+j] = din[32+j];
      assign dout[48+j] = din[48+j];
    end
  end

endmodule

module rectangle_round_ctrl #(
  parameter int NR = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [63:0] pt_i,
  input  logic [79:0] key_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  round_o,
  output logic [63:0] ct_o,
  output logic        ct_valid_o,
  input  logic        ct_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} fsm_t;

  localparam logic [4:0] LAST_ROUND = 5'(NR - 1);

  fsm_t        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  rc_q, rc_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] ct_q, ct_d;
  logic        ct_valid_q, ct_valid_d;

  logic [63:0] ark, sb_out, sr_out, ksb_out;
  logic [79:0] ks_out;
  logic [15:0] r1, r2, r3, k0s, k1s, k2s, k3s, k4;
  logic [4:0]  rc_next;

  // Round datapath: AddRoundKey -> S-box layer -> ShiftRow
  assign ark = state_q ^ key_q[63:0];

  rectangle_sbox_cols #(.COLS(16)) u_text_sbox (.din(ark),         .dout(sb_out));
  rectangle_sbox_cols #(.COLS(4))  u_key_sbox  (.din(key_q[63:0]), .dout(ksb_out));

  assign r1     = sb_out[31:16];
  assign r2     = sb_out[47:32];
  assign r3     = sb_out[63:48];
  assign sr_out = {{r3[2:0], r3[15:3]}, {r2[3:0], r2[15:4]}, {r1[14:0], r1[15]}, sb_out[15:0]};

  // Key schedule: substituted rows feed a generalised Feistel shuffle plus round constant
  assign k0s     = ksb_out[15:0];
  assign k1s     = ksb_out[31:16];
  assign k2s     = ksb_out[47:32];
  assign k3s     = ksb_out[63:48];
  assign k4      = key_q[79:64];
  assign ks_out  = {k0s,
                    {k3s[3:0], k3s[15:4]} ^ k4,
                    k3s,
                    k2s,
                    {k0s[7:0], k0s[15:8]} ^ k1s ^ {11'd0, rc_q}};
  assign rc_next = {rc_q[3:0], rc_q[4] ^ rc_q[2]};

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    key_d      = key_q;
    rc_d       = rc_q;
    round_d    = round_q;
    ct_d       = ct_q;
    ct_valid_d = ct_valid_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = pt_i;
          key_d   = key_i;
          rc_d    = 5'h01;
          round_d = 5'd0;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        state_d = sr_out;
        key_d   = ks_out;
        rc_d    = rc_next;
        round_d = round_q + 5'd1;
        if (round_q == LAST_ROUND) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        ct_d       = ark;
        ct_valid_d = 1'b1;
        fsm_d      = S_DONE;
      end
      S_DONE: begin
        if (ct_ack_i) begin
          ct_valid_d = 1'b0;
          fsm_d      = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      state_q    <= '0;
      key_q      <= '0;
      rc_q       <= 5'h01;
      round_q    <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      key_q      <= key_d;
      rc_q       <= rc_d;
      round_q    <= round_d;
      ct_q       <= ct_d;
      ct_valid_q <= ct_valid_d;
    end
  end

  assign ready_o    = (fsm_q == S_IDLE);
  assign busy_o     = (fsm_q == S_RUN) || (fsm_q == S_FINAL);
  assign round_o    = round_q;
  assign ct_o       = ct_q;
  assign ct_valid_o = ct_valid_q;

endmodule

// File: tb/tb_rectangle_round_ctrl.sv
// Randomised bench for rectangle_round_ctrl against a row/array model of RECTANGLE-80.

module tb_rectangle_round_ctrl;

  localparam int NR = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] pt_i = '0;
  logic [79:0] key_i = '0;
  logic        ct_ack_i = 1'b0;
  logic        ready_o, busy_o, ct_valid_o;
  logic [4:0]  round_o;
  logic [63:0] ct_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rectangle_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pt_i(pt_i), .key_i(key_i),
    .ready_o(ready_o), .busy_o(busy_o), .round_o(round_o), .ct_o(ct_o),
    .ct_valid_o(ct_valid_o), .ct_ack_i(ct_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} >> (16 - n);
    return d[15:0];
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] tbl;
    logic [15:0] s[4];
    logic [15:0] k[5];
    logic [15:0] t[5];
    logic [4:0]  rc;
    logic [3:0]  nib, y;
    tbl = 64'h24F8_D30B_97E1_AC56;
    rc  = 5'h01;
    for (int i = 0; i < 4; i++) s[i] = pt[16*i +: 16];
    for (int i = 0; i < 5; i++) k[i] = key[16*i +: 16];
    for (int rnd = 0; rnd < NR; rnd++) begin
      for (int i = 0; i < 4; i++) s[i] = s[i] ^ k[i];
      for (int c = 0; c < 16; c++) begin
        nib = {s[3][c], s[2][c], s[1][c], s[0][c]};
        y   = tbl[int'(nib)*4 +: 4];
        for (int i = 0; i < 4; i++) s[i][c] = y[i];
      end
      s[1] = rotl(s[1], 1);
      s[2] = rotl(s[2], 12);
      s[3] = rotl(s[3], 13);
      for (int c = 0; c < 4; c++) begin
        nib = {k[3][c], k[2][c], k[1][c], k[0][c]};
        y   = tbl[int'(nib)*4 +: 4];
        for (int i = 0; i < 4; i++) k[i][c] = y[i];
      end
      t[0] = rotl(k[0], 8) ^ k[1];
      t[1] = k[2];
      t[2] = k[3];
      t[3] = rotl(k[3], 12) ^ k[4];
      t[4] = k[0];
      t[0][4:0] = t[0][4:0] ^ rc;
      for (int i = 0; i < 5; i++) k[i] = t[i];
      rc = {rc[3:0], rc[4] ^ rc[2]};
    end
    return {s[3] ^ k[3], s[2] ^ k[2], s[1] ^ k[1], s[0] ^ k[0]};
  endfunction

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Drives a one-cycle start; returns at the negedge after the accepting edge
  // with c0 = posedge count at that point.
  task automatic launch(input logic [63:0] pt, input logic [79:0] key, output int c0);
    @(negedge clk);
    start_i = 1'b1;
    pt_i    = pt;
    key_i   = key;
    @(negedge clk);
    start_i = 1'b0;
    c0      = cyc;
  endtask

  task automatic wait_valid(input int c0, output int lat);
    int n;
    n = 0;
    while (ct_valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - c0;
  endtask

  task automatic test_reset();
    int c0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || round_o !== 5'd0 || ct_valid_o !== 1'b0 || ct_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_init: ready=%b busy=%b round=%0d valid=%b ct=%h, want 1 0 0 0 0",
               ready_o, busy_o, round_o, ct_valid_o, ct_o);
    end
    @(negedge clk) rst = 1'b0;
    launch({$urandom, $urandom}, rand_key(), c0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || round_o !== 5'd0 || ct_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ready=%b busy=%b round=%0d valid=%b, want 1 0 0 0",
               ready_o, busy_o, round_o, ct_valid_o);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_golden(input logic [63:0] pt, input logic [79:0] key);
    int c0, lat;
    logic [63:0] exp;
    exp = ref_enc(pt, key);
    launch(pt, key, c0);
    checks++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0 || round_o !== 5'd0) begin
      errors++;
      $display("FAIL golden_run_start: busy=%b ready=%b round=%0d, want 1 0 0", busy_o, ready_o, round_o);
    end
    wait_valid(c0, lat);
    checks++;
    if (lat !== NR + 1) begin
      errors++;
      $display("FAIL golden_latency: got %0d want %0d", lat, NR + 1);
    end
    checks++;
    if (ct_o !== exp || round_o !== 5'(NR)) begin
      errors++;
      $display("FAIL golden_ct: ct=%h round=%0d want ct=%h round=%0d", ct_o, round_o, exp, NR);
    end
    ct_ack_i = 1'b1;
    @(negedge clk) ct_ack_i = 1'b0;
    checks++;
    if (ct_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL golden_ack: valid=%b ready=%b want 0 1", ct_valid_o, ready_o);
    end
  endtask

  task automatic test_hold();
    int c0, lat, bad;
    logic [63:0] pt, exp;
    logic [79:0] key;
    pt  = {$urandom, $urandom};
    key = rand_key();
    exp = ref_enc(pt, key);
    launch(pt, key, c0);
    repeat (3) @(negedge clk);
    ct_ack_i = 1'b1;
    @(negedge clk) ct_ack_i = 1'b0;
    wait_valid(c0, lat);
    checks++;
    if (lat !== NR + 1 || ct_o !== exp) begin
      errors++;
      $display("FAIL hold_result: lat=%0d ct=%h want lat=%0d ct=%h", lat, ct_o, NR + 1, exp);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ct_o !== exp || ct_valid_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d of 10 cycles unstable, want 0 (ct=%h valid=%b)", bad, ct_o, ct_valid_o);
    end
    ct_ack_i = 1'b1;
    @(negedge clk) ct_ack_i = 1'b0;
    checks++;
    if (ct_valid_o !== 1'b0 || ready_o !== 1'b1 || ct_o !== exp) begin
      errors++;
      $display("FAIL hold_ack: valid=%b ready=%b ct=%h want 0 1 %h", ct_valid_o, ready_o, ct_o, exp);
    end
  endtask

  task automatic test_ignored_start();
    int c0, lat, n;
    logic [63:0] pt, exp;
    logic [79:0] key;
    pt  = {$urandom, $urandom};
    key = rand_key();
    exp = ref_enc(pt, key);
    launch(pt, key, c0);
    n = 0;
    while (round_o !== 5'd7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start_i = 1'b1;
    pt_i    = ~pt;
    key_i   = rand_key();
    @(negedge clk) start_i = 1'b0;
    wait_valid(c0, lat);
    checks++;
    if (lat !== NR + 1 || ct_o !== exp) begin
      errors++;
      $display("FAIL ignored_start_run: lat=%0d ct=%h want lat=%0d ct=%h", lat, ct_o, NR + 1, exp);
    end
    start_i  = 1'b1;
    pt_i     = {$urandom, $urandom};
    ct_ack_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    ct_ack_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || ct_valid_o !== 1'b0 || busy_o !== 1'b0 || round_o !== 5'(NR) || ct_o !== exp) begin
      errors++;
      $display("FAIL ignored_start_done: ready=%b valid=%b busy=%b round=%0d ct=%h want 1 0 0 %0d %h",
               ready_o, ct_valid_o, busy_o, round_o, ct_o, NR, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_idle: busy=%b ready=%b want 0 1", busy_o, ready_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int c0, lat, n, seen;
    logic [63:0] pt, exp;
    logic [79:0] key;
    launch({$urandom, $urandom}, rand_key(), c0);
    n = 0;
    while (round_o !== 5'd12 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (round_o !== 5'd12) begin
      errors++;
      $display("FAIL abort_reach_round: round=%0d want 12", round_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ct_valid_o !== 1'b0 || ct_o !== 64'd0 || ready_o !== 1'b1 || round_o !== 5'd0) begin
      errors++;
      $display("FAIL abort_reset: valid=%b ct=%h ready=%b round=%0d want 0 0 1 0",
               ct_valid_o, ct_o, ready_o, round_o);
    end
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (ct_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: valid/busy high in %0d cycles, want 0", seen);
    end
    pt  = {$urandom, $urandom};
    key = rand_key();
    exp = ref_enc(pt, key);
    launch(pt, key, c0);
    wait_valid(c0, lat);
    checks++;
    if (lat !== NR + 1 || ct_o !== exp) begin
      errors++;
      $display("FAIL abort_fresh: lat=%0d ct=%h want lat=%0d ct=%h", lat, ct_o, NR + 1, exp);
    end
    ct_ack_i = 1'b1;
    @(negedge clk) ct_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s_cyc[3];
    int c0, lat;
    logic [63:0] pt, exp;
    logic [79:0] key;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pt  = {$urandom, $urandom};
      key = rand_key();
      exp = ref_enc(pt, key);
      s_cyc[i] = cyc;
      start_i  = 1'b1;
      pt_i     = pt;
      key_i    = key;
      @(negedge clk);
      start_i = 1'b0;
      c0      = cyc;
      wait_valid(c0, lat);
      checks++;
      if (lat !== NR + 1 || ct_o !== exp) begin
        errors++;
        $display("FAIL b2b_result[%0d]: lat=%0d ct=%h want lat=%0d ct=%h", i, lat, ct_o, NR + 1, exp);
      end
      ct_ack_i = 1'b1;
      @(negedge clk) ct_ack_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b want 1", i, ready_o);
      end
      if (i > 0) begin
        checks++;
        if (s_cyc[i] - s_cyc[i-1] != NR + 3) begin
          errors++;
          $display("FAIL b2b_interval[%0d]: got %0d want %0d", i, s_cyc[i] - s_cyc[i-1], NR + 3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden(64'h0, 80'h0);
    test_golden(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    test_hold();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
